// File: rtl/game_key_pkg.sv
// Shared types and constants for the PS/2 game keyboard front end:
// frame receiver states, scancodes of interest and the held-key bit layout.
package game_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] SC_BREAK       = 8'hF0;
    localparam logic [7:0] SC_EXT         = 8'hE0;
    localparam logic [7:0] SC_A           = 8'h1C;
    localparam logic [7:0] SC_D           = 8'h23;
    localparam logic [7:0] SC_W           = 8'h1D;
    localparam logic [7:0] SC_SPACE       = 8'h29;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;

    localparam logic [1:0] KEY_LEFT   = 2'd0;
    localparam logic [1:0] KEY_RIGHT  = 2'd1;
    localparam logic [1:0] KEY_JUMP   = 2'd2;
    localparam logic [1:0] KEY_ACTION = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_map_t;

    // Extended codes only match after an E0 prefix, so A and the left arrow
    // can share a key bit without colliding in the lookup.
    function automatic key_map_t map_scancode(input logic [7:0] code, input logic ext);
        key_map_t r;
        r.hit = 1'b1;
        r.idx = KEY_LEFT;
        if (!ext) begin
            case (code)
                SC_A:     r.idx = KEY_LEFT;
                SC_D:     r.idx = KEY_RIGHT;
                SC_W:     r.idx = KEY_JUMP;
                SC_SPACE: r.idx = KEY_ACTION;
                default:  r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_ARROW_LEFT:  r.idx = KEY_LEFT;
                SC_ARROW_RIGHT: r.idx = KEY_RIGHT;
                SC_ARROW_UP:    r.idx = KEY_JUMP;
                default:        r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, walks start/data/parity/stop
// on falling ps2_clk edges and abandons a frame that stalls too long.
module ps2_rx
    import game_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 130000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // bit 0 carries ps2_clk, bit 1 carries ps2_data
    logic [1:0]   meta_q, meta_d;
    logic [1:0]   sync_q, sync_d;
    logic         clk_prev_q, clk_prev_d;
    frame_state_t state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [TW-1:0] timer_q, timer_d;

    logic fall;
    logic din;

    assign fall      = clk_prev_q & ~sync_q[0];
    assign din       = sync_q[1];
    assign data_byte = shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        meta_d     = {ps2_data, ps2_clk};
        sync_d     = meta_q;
        clk_prev_d = sync_q[0];
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        timer_d    = timer_q;
        byte_valid = 1'b0;
        err        = 1'b0;

        if (fall) begin
            // an edge always beats a timeout landing in the same cycle
            timer_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!din) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = din;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (din && (^{shift_q, par_q})) begin
                        byte_valid = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                timer_d = '0;
                shift_d = '0;
                err     = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            timer_d = '0;
        end
    end

endmodule

// File: rtl/game_ps2_keys.sv
// PS/2 keyboard to game-controller bridge: turns make/break scancode
// sequences into a held-key vector for left, right, jump and action.
module game_ps2_keys
    import game_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 130000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    logic [3:0] key_q, key_d;
    logic [7:0] scancode_q, scancode_d;
    logic       code_valid_q, code_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    key_map_t   lk;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_byte  (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q        <= '0;
            scancode_q   <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
        end else begin
            key_q        <= key_d;
            scancode_q   <= scancode_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
        end
    end

    always_comb begin
        key_d        = key_q;
        scancode_d   = scancode_q;
        code_valid_d = rx_valid;
        frame_err_d  = rx_err;
        brk_d        = brk_q;
        ext_d        = ext_q;
        lk           = map_scancode(rx_byte, ext_q);

        // rejected frames leave the prefix flags alone so a retry can complete
        if (rx_valid) begin
            scancode_d = rx_byte;
            if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                if (lk.hit) begin
                    key_d[lk.idx] = ~brk_q;
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    assign key        = key_q;
    assign scancode   = scancode_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_game_ps2_keys.sv
// Self-checking bench: directed scenarios plus random scancode streams,
// compared against a table-driven make/break model of the keyboard decoder.
module tb_game_ps2_keys;

    localparam int TO   = 300;
    localparam int HALF = 10;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key;
    logic [7:0] scancode;
    logic       code_valid;
    logic       frame_err;

    game_ps2_keys #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key        (key),
        .scancode   (scancode),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int txn      = 0;

    int         cv_cnt = 0;
    int         err_cnt = 0;
    int         glitch_cnt = 0;
    logic [3:0] last_key = '0;
    logic [7:0] last_sc = '0;
    logic [3:0] prev_key = '0;
    logic [7:0] prev_sc = '0;

    // reference model
    int         map_norm [256];
    int         map_ext  [256];
    logic [3:0] key_m;
    logic [7:0] sc_m;
    bit         brk_m;
    bit         ext_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_key = key;
            prev_sc  = scancode;
        end else begin
            if (code_valid) begin
                cv_cnt++;
                last_key = key;
                last_sc  = scancode;
            end else if (key !== prev_key || scancode !== prev_sc) begin
                glitch_cnt++;
            end
            if (frame_err) err_cnt++;
            prev_key = key;
            prev_sc  = scancode;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        key_m = '0;
        sc_m  = '0;
        brk_m = 0;
        ext_m = 0;
    endtask

    task automatic model_apply(input logic [7:0] b);
        int idx;
        sc_m = b;
        if (b == 8'hF0) brk_m = 1;
        else if (b == 8'hE0) ext_m = 1;
        else begin
            idx = ext_m ? map_ext[b] : map_norm[b];
            if (idx >= 0) key_m[idx] = ~brk_m;
            brk_m = 0;
            ext_m = 0;
        end
    endtask

    task automatic ps2_bit(input logic v, input int extra);
        ps2_data = v;
        wait_clk(HALF + extra);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                             input int nbits, input int stretch);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i], (i == 5) ? stretch : 0);
        ps2_data = 1'b1;
    endtask

    task automatic do_txn(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                          input int stretch);
        int  cv0;
        int  e0;
        bit  ok;
        cv0 = cv_cnt;
        e0  = err_cnt;
        send_bits(b, bad_par, bad_stop, 11, stretch);
        wait_clk(30);
        ok = !bad_par && !bad_stop;
        if (ok) model_apply(b);
        chk("code_valid_pulses", cv_cnt - cv0, ok ? 1 : 0);
        chk("frame_err_pulses", err_cnt - e0, ok ? 0 : 1);
        chk("scancode", {24'd0, scancode}, {24'd0, sc_m});
        chk("key", {28'd0, key}, {28'd0, key_m});
        if (ok) chk("key_at_code_valid", {28'd0, last_key}, {28'd0, key_m});
        txn++;
        $display("txn %0d byte=%02h bad_par=%0d bad_stop=%0d stretch=%0d key=%b scancode=%02h",
                 txn, b, bad_par, bad_stop, stretch, key, scancode);
    endtask

    initial begin
        logic [7:0] pool [9];
        logic [7:0] b;
        int         cv0;
        int         e0;

        for (int i = 0; i < 256; i++) begin
            map_norm[i] = -1;
            map_ext[i]  = -1;
        end
        map_norm[8'h1C] = 0; map_norm[8'h23] = 1; map_norm[8'h1D] = 2; map_norm[8'h29] = 3;
        map_ext[8'h6B]  = 0; map_ext[8'h74]  = 1; map_ext[8'h75]  = 2;
        pool = '{8'hF0, 8'hE0, 8'h1C, 8'h23, 8'h1D, 8'h29, 8'h6B, 8'h74, 8'h75};
        model_reset();

        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_clk(5);
        @(negedge clk);
        chk("rst_key", {28'd0, key}, 32'd0);
        chk("rst_scancode", {24'd0, scancode}, 32'd0);
        chk("rst_code_valid", {31'd0, code_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        wait_clk(20);
        chk("post_rst_err", err_cnt, 0);

        // make A, break A, extended make/break mix
        do_txn(8'h1C, 0, 0, 0);
        do_txn(8'hF0, 0, 0, 0);
        do_txn(8'h1C, 0, 0, 0);
        do_txn(8'hE0, 0, 0, 0);
        do_txn(8'h75, 0, 0, 0);
        do_txn(8'h29, 0, 0, 0);
        chk("key_1100", {28'd0, key}, 32'hC);
        do_txn(8'hE0, 0, 0, 0);
        do_txn(8'hF0, 0, 0, 0);
        do_txn(8'h75, 0, 0, 0);
        chk("key_1000", {28'd0, key}, 32'h8);
        do_txn(8'h23, 1, 0, 0);
        do_txn(8'h23, 0, 1, 0);

        // stray edge with data high while idle
        e0 = err_cnt;
        ps2_bit(1'b1, 0);
        wait_clk(20);
        chk("idle_high_err", err_cnt - e0, 1);

        // partial frame abandoned by the timeout
        e0 = err_cnt; cv0 = cv_cnt;
        send_bits(8'h23, 0, 0, 4, 0);
        wait_clk(TO + 50);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_no_cv", cv_cnt - cv0, 0);
        do_txn(8'h23, 0, 0, 0);
        chk("key1_after_timeout", {31'd0, key[1]}, 32'd1);

        // slow but legal bit gap just inside the timeout
        do_txn(8'h1D, 0, 0, TO - 40);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            b = (sel == 9) ? 8'($urandom_range(0, 255)) : pool[sel];
            do_txn(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), 0);
        end

        // establish key=0011, then reset in the middle of a frame
        do_txn(8'h1C, 0, 0, 0);
        do_txn(8'h1C, 0, 0, 0);
        do_txn(8'h23, 0, 0, 0);
        do_txn(8'hF0, 0, 0, 0);
        do_txn(8'h1D, 0, 0, 0);
        do_txn(8'hF0, 0, 0, 0);
        do_txn(8'h29, 0, 0, 0);
        chk("key_0011", {28'd0, key}, 32'h3);
        send_bits(8'h29, 0, 0, 5, 0);
        rst = 1'b0;
        wait_clk(3);
        @(negedge clk);
        chk("midrst_key", {28'd0, key}, 32'd0);
        chk("midrst_scancode", {24'd0, scancode}, 32'd0);
        chk("midrst_code_valid", {31'd0, code_valid}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        model_reset();
        e0 = err_cnt;
        rst = 1'b1;
        wait_clk(20);
        chk("midrst_no_err", err_cnt - e0, 0);
        do_txn(8'h29, 0, 0, 0);

        chk("key_change_without_code_valid", glitch_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_ps2_keys.md
GAME_PS2_KEYS -- requirements
Module: game_ps2_keys

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 130000, idle-cycle limit after which a partial PS/2 frame is discarded (about 2 ms at 65 MHz).
REQ-002 clk  input  1  system clock; all logic is in this single domain.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data from the keyboard; asynchronous to clk.
REQ-006 key  output  4  held-key vector feeding top_game: [0] left, [1] right, [2] jump, [3] action.
REQ-007 scancode  output  8  last valid received byte.
REQ-008 code_valid  output  1  one-cycle pulse when scancode updates.
REQ-009 frame_err  output  1  one-cycle pulse when a frame is rejected (start, parity, stop or timeout).

Function
REQ-010 Each of ps2_clk and ps2_data SHALL pass through a 2-FF synchronizer; a PS/2 falling edge is a synchronized 1->0 transition of ps2_clk.
REQ-011 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP, and advance only on a PS/2 falling edge.
REQ-012 IDLE: data=0 -> DATA with the bit counter at 0; data=1 -> stay in IDLE and pulse frame_err.
REQ-013 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-014 PARITY: sample the parity bit -> STOP; the frame needs odd parity over the 8 data bits plus the parity bit.
REQ-015 STOP: stop bit = 1 with good parity -> byte accepted; otherwise frame_err; both cases -> IDLE.
REQ-016 An accepted byte SHALL update scancode and pulse code_valid in the cycle after the stop-bit edge (latency 1).
REQ-017 A timeout counter SHALL reset on every PS/2 falling edge and count otherwise while not in IDLE.
REQ-018 On reaching TIMEOUT_CYCLES-1 the counter SHALL force IDLE, discard the partial byte and pulse frame_err.
REQ-019 An edge and a timeout in the same cycle: the edge wins and no timeout occurs.
REQ-020 The decoder SHALL hold flags brk and ext, updated on each accepted byte.
REQ-021 Byte 0xF0 sets brk; byte 0xE0 sets ext; neither changes key.
REQ-022 Any other byte is looked up with the current ext flag; if mapped, key[i] <= ~brk. Mapped or not, brk and ext then clear.
REQ-023 Map with ext=0: 0x1C->0, 0x23->1, 0x1D->2, 0x29->3.
REQ-024 Map with ext=1: 0x6B->0, 0x74->1, 0x75->2.
REQ-025 key SHALL update in the same cycle as code_valid; several bits may be set at once.
REQ-026 An aliased pair (A and left arrow) shares one bit; the last make or break on either wins.
REQ-027 A frame_err SHALL NOT clear brk, ext or key.

Reset
REQ-028 On rst=0, key=0, scancode=0x00, code_valid=0 and frame_err=0; the FSM goes to IDLE; the counters, brk, ext and the synchronizers (to 1) clear.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame.
REQ-030 After rst rises, no frame_err is produced by synchronizer settling.

Structure
REQ-031 Package game_key_pkg SHALL hold the frame-state enum, the scancode constants (F0, E0, the mapped codes) and the key index constants KEY_LEFT, KEY_RIGHT, KEY_JUMP and KEY_ACTION.
REQ-032 The frame receiver (REQ-010 to REQ-019) SHALL be the sub-module ps2_rx, with outputs byte, byte_valid and err.
REQ-033 The decoder logic SHALL stay in game_ps2_keys.

Verification
REQ-034 Send frame 0x1C with correct parity -> code_valid pulses once, scancode=0x1C, key=4'b0001.
REQ-035 Then send 0xF0 and 0x1C -> key=4'b0000; a code_valid pulse occurs for each byte.
REQ-036 Send E0 75, then 29 -> key=4'b1100; then send E0 F0 75 -> key=4'b1000.
REQ-037 Send 0x23 with a wrong parity bit -> frame_err pulses, no code_valid, key unchanged.
REQ-038 Send 4 bits, then idle for TIMEOUT_CYCLES -> frame_err pulses once; a following 0x23 frame -> key[1]=1.
REQ-039 Pull rst low mid-frame after key=4'b0011 -> all outputs 0; the next full frame decodes correctly.
